// File: rtl/cache_controller.sv
// Write-back, write-allocate controller for a direct-mapped data cache.
// Misses stall the CPU while the victim line is written back and the new line is refilled word by word.
module cache_controller #(
    parameter int ADDR_BITS  = 32,
    parameter int WORD_BITS  = 32,
    parameter int TAG_BITS   = 22,
    parameter int LINE_WORDS = 4,
    parameter int WORD_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [WORD_BITS-1:0] cpu_din,
    output logic [WORD_BITS-1:0] cpu_dout,
    output logic                 cpu_stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    output logic [WORD_BITS-1:0] cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [WORD_BITS-1:0] cache_dout,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_dout,
    input  logic [WORD_BITS-1:0] mem_din,
    input  logic                 mem_ack
);

    localparam int CNT_W    = $clog2(LINE_WORDS);
    localparam int OFF_W    = $clog2(WORD_BYTES);
    localparam int LINE_LSB = CNT_W + OFF_W;
    localparam int IDX_HI   = ADDR_BITS - TAG_BITS - 1;

    typedef enum logic [1:0] {S_IDLE, S_BACK, S_FILL, S_RETRY} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_last;
    logic [ADDR_BITS-1:0] w_line_addr;
    logic [ADDR_BITS-1:0] w_back_addr;

    assign w_last      = (r_cnt == CNT_W'(LINE_WORDS - 1));
    assign w_line_addr = {cpu_addr[ADDR_BITS-1:LINE_LSB], r_cnt, {OFF_W{1'b0}}};
    // Victim address is rebuilt from the stored tag, not the requesting tag
    assign w_back_addr = {cache_tag, cpu_addr[IDX_HI:LINE_LSB], r_cnt, {OFF_W{1'b0}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (cpu_req && !cache_hit) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (cache_valid && cache_dirty) ? S_BACK : S_FILL;
                end
            end
            S_BACK: begin
                if (mem_ack) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) w_state_nxt = S_RETRY;
                end
            end
            S_RETRY: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall  = 1'b0;
        cache_addr = cpu_addr;
        cache_din  = cpu_din;
        cache_load = 1'b0;
        cache_edit = 1'b0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = w_line_addr;
        mem_dout   = cache_dout;
        case (r_state)
            S_IDLE: begin
                cpu_stall  = cpu_req & ~cache_hit;
                cache_edit = cpu_req & cpu_we & cache_hit;
            end
            S_BACK: begin
                cpu_stall  = 1'b1;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                cache_addr = w_line_addr;
                mem_addr   = w_back_addr;
            end
            S_FILL: begin
                cpu_stall  = 1'b1;
                mem_cs     = 1'b1;
                cache_addr = w_line_addr;
                cache_din  = mem_din;
                cache_load = mem_ack;
            end
            S_RETRY: cpu_stall = 1'b1;
            default: cpu_stall = 1'b0;
        endcase
        // Reset kills every strobe at once so an in-flight memory access is abandoned
        if (!rst) begin
            cpu_stall  = 1'b0;
            cache_load = 1'b0;
            cache_edit = 1'b0;
            mem_cs     = 1'b0;
            mem_we     = 1'b0;
        end
    end

    assign cpu_dout      = cache_dout;
    assign cache_invalid = 1'b0;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural cache array and memory around the DUT, an access-level
// reference model predicting memory traffic, stall length and load data, plus literal pins.
module tb_cache_controller;

    localparam int DLY   = 2;
    localparam int LIMIT = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_din, cpu_dout;
    logic        cpu_stall;
    logic [31:0] cache_addr, cache_din;
    logic        cache_load, cache_edit, cache_invalid;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [21:0] cache_tag;
    logic [31:0] cache_dout;
    logic        mem_cs, mem_we;
    logic [31:0] mem_addr, mem_dout, mem_din;
    logic        mem_ack;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
        .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
        .cache_invalid(cache_invalid), .cache_din(cache_din),
        .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
        .cache_tag(cache_tag), .cache_dout(cache_dout),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // cache array environment
    logic        cv [64];
    logic        cd [64];
    logic [21:0] ct [64];
    logic [31:0] cdat [64][4];

    assign cache_valid = cv[cache_addr[9:4]];
    assign cache_dirty = cd[cache_addr[9:4]];
    assign cache_tag   = ct[cache_addr[9:4]];
    assign cache_hit   = cv[cache_addr[9:4]] && (ct[cache_addr[9:4]] == cache_addr[31:10]);
    assign cache_dout  = cdat[cache_addr[9:4]][cache_addr[3:2]];

    // main memory and architectural (CPU-visible) memory
    logic [31:0] mem  [bit [31:0]];
    logic [31:0] arch [bit [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A0000);
    endfunction
    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : (a ^ 32'h5A5A0000);
    endfunction

    // reference model: line-level view of the cache plus the traffic expected per access
    typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
    txn_t        exp_q[$];
    logic [31:0] rd_log[$];
    logic        mv [64];
    logic        md [64];
    logic [21:0] mt [64];

    int checks = 0, errors = 0;
    int n_done = 0, issue_done = 0;
    int exp_stall = 0, stall_cnt = 0, last_stall = 0;
    int hold_left = 0, loads = 0, wcnt = 0;
    logic        exp_we;
    logic [31:0] exp_addr, exp_din, last_dout;

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
        end
    endtask
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic plan(input logic we, input logic [31:0] a);
        logic [5:0]  idx;
        logic [21:0] tg;
        int          nw;
        txn_t        t;
        idx = a[9:4];
        tg  = a[31:10];
        nw  = 0;
        if (!(mv[idx] && mt[idx] == tg)) begin
            if (mv[idx] && md[idx]) begin
                for (int w = 0; w < 4; w++) begin
                    t.we = 1'b1; t.addr = {mt[idx], idx, 2'(w), 2'b00}; t.data = arch_rd(t.addr);
                    exp_q.push_back(t);
                end
                nw += 4;
            end
            for (int w = 0; w < 4; w++) begin
                t.we = 1'b0; t.addr = {tg, idx, 2'(w), 2'b00}; t.data = 32'h0;
                exp_q.push_back(t);
            end
            nw += 4;
            mv[idx] = 1'b1; mt[idx] = tg; md[idx] = 1'b0;
            exp_stall = 2 + nw * DLY + hold_left;
        end else begin
            exp_stall = 0;
        end
        if (we) md[idx] = 1'b1;
    endtask

    // compare process plus cache/memory environment
    initial begin
        logic        pl, pe, pmw;
        logic [31:0] pa, pd, pma, pmd;
        txn_t        t;
        mem_ack = 1'b0;
        mem_din = 32'h0;
        for (int i = 0; i < 64; i++) begin
            cv[i] = 1'b0; cd[i] = 1'b0; ct[i] = '0;
            mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0;
            for (int w = 0; w < 4; w++) cdat[i][w] = 32'h0;
        end
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk1("rst_stall", cpu_stall, 1'b0);
                chk1("rst_mem_cs", mem_cs, 1'b0);
                chk1("rst_load", cache_load, 1'b0);
                chk1("rst_edit", cache_edit, 1'b0);
                stall_cnt = 0;
            end else begin
                chk1("invalid", cache_invalid, 1'b0);
                chk1("edit_rule", cache_edit, cpu_req & cpu_we & ~cpu_stall);
                if (mem_cs) chk1("cs_stall", cpu_stall, 1'b1);
                if (mem_cs && mem_ack) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_txn actual=%h required=none t=%0t", mem_addr, $time);
                    end else begin
                        t = exp_q.pop_front();
                        chk1("mem_we", mem_we, t.we);
                        chk32("mem_addr", mem_addr, t.addr);
                        if (t.we) chk32("mem_dout", mem_dout, t.data);
                        else rd_log.push_back(mem_addr);
                    end
                    chk1("load_strobe", cache_load, ~mem_we);
                end else begin
                    chk1("load_idle", cache_load, 1'b0);
                end
                if (cpu_req && cpu_stall) stall_cnt++;
                if (cpu_req && !cpu_stall) begin
                    chk32("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
                    chk32("txn_left", 32'(exp_q.size()), 32'h0);
                    if (!exp_we) chk32("cpu_dout", cpu_dout, arch_rd({exp_addr[31:2], 2'b00}));
                    else arch[{exp_addr[31:2], 2'b00}] = exp_din;
                    last_stall = stall_cnt;
                    last_dout  = cpu_dout;
                    stall_cnt  = 0;
                    n_done++;
                end
            end
            pl = cache_load; pe = cache_edit; pa = cache_addr; pd = cache_din;
            pmw = mem_cs && mem_ack && mem_we; pma = mem_addr; pmd = mem_dout;
            @(posedge clk);
            if (pl) begin
                cv[pa[9:4]] = 1'b1; cd[pa[9:4]] = 1'b0; ct[pa[9:4]] = pa[31:10];
                cdat[pa[9:4]][pa[3:2]] = pd;
                loads++;
            end
            if (pe) begin
                cd[pa[9:4]] = 1'b1;
                cdat[pa[9:4]][pa[3:2]] = pd;
            end
            if (pmw) mem[pma] = pmd;
            #1;
            if (mem_cs) begin
                mem_din = mem_rd(mem_addr);
                if (hold_left > 0) begin
                    mem_ack = 1'b0; hold_left--;
                end else if (wcnt == DLY - 1) begin
                    mem_ack = 1'b1; wcnt = 0;
                end else begin
                    mem_ack = 1'b0; wcnt++;
                end
            end else begin
                mem_ack = 1'b0; wcnt = 0;
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input int hold);
        @(posedge clk); #1;
        hold_left = hold;
        plan(we, a);
        exp_we = we; exp_addr = a; exp_din = d;
        issue_done = n_done;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (n_done == issue_done && k < LIMIT) begin
            @(posedge clk); #1;
            k++;
        end
        if (n_done == issue_done) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=%0d cycles required=completion", name, k);
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_din = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk1("reset_stall", cpu_stall, 1'b0);
        chk1("reset_cs", mem_cs, 1'b0);

        // cold load miss
        rd_log.delete(); base = loads;
        issue(1'b0, 32'h0000_0104, 32'h0, 0);
        wait_done("cold_load");
        chk32("cold_rd_n", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            chk32("cold_rd_addr", rd_log[i], 32'h100 + 32'(4 * i));
        chk32("cold_loads", 32'(loads - base), 32'd4);
        chk32("cold_stall", 32'(last_stall), 32'd10);
        chk32("cold_dout", last_dout, 32'h5A5A_0104);

        // store hit
        issue(1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 0);
        wait_done("store_hit");
        chk32("store_hit_stall", 32'(last_stall), 32'd0);
        chk1("store_hit_dirty", cd[6'h10], 1'b1);

        // dirty conflict miss
        rd_log.delete();
        issue(1'b0, 32'h0000_0504, 32'h0, 0);
        wait_done("dirty_load");
        chk32("wb_word", mem_rd(32'h108), 32'hDEAD_BEEF);
        chk32("dirty_stall", 32'(last_stall), 32'd18);
        chk32("dirty_rd0", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, 32'h500);
        chk32("dirty_dout", last_dout, 32'h5A5A_0504);

        // store miss with clean victim
        issue(1'b1, 32'h0000_0904, 32'h1234_5678, 0);
        wait_done("store_miss");
        chk32("store_miss_stall", 32'(last_stall), 32'd10);
        chk1("store_miss_dirty", cd[6'h10], 1'b1);
        chk32("store_miss_word", cdat[6'h10][1], 32'h1234_5678);

        // reset during refill
        base = loads;
        issue(1'b0, 32'h0000_0204, 32'h0, 0);
        for (int k = 0; k < LIMIT && loads < base + 2; k++) begin
            @(posedge clk); #1;
        end
        chk32("pre_reset_loads", 32'(loads - base), 32'd2);
        #1 rst = 1'b0; cpu_req = 1'b0;
        #1;
        chk1("abort_cs", mem_cs, 1'b0);
        chk1("abort_load", cache_load, 1'b0);
        chk1("abort_stall", cpu_stall, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk1("post_reset_stall", cpu_stall, 1'b0);
        chk1("post_reset_cs", mem_cs, 1'b0);
        issue(1'b0, 32'h0000_0204, 32'h0, 0);
        wait_done("post_reset_hit");
        chk32("post_reset_hit_stall", 32'(last_stall), 32'd0);

        // memory holds ack low
        issue(1'b0, 32'h0000_0300, 32'h0, 50);
        @(posedge clk); #1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!cpu_stall || mem_addr !== 32'h300 || cache_load || !mem_cs) begin
                chk1("hold_stall", cpu_stall, 1'b1);
                chk32("hold_addr", mem_addr, 32'h300);
                chk1("hold_load", cache_load, 1'b0);
                chk1("hold_cs", mem_cs, 1'b1);
            end else begin
                checks++;
            end
        end
        wait_done("hold");
        chk32("hold_total_stall", 32'(last_stall), 32'd60);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Write-back, write-allocate controller between the CPU data port and the direct-mapped data cache array.
- Drives the cache's load/edit/invalid strobes and address/data inputs; consumes its hit/valid/dirty/tag/dout outputs.
- On a miss it runs multi-cycle word-by-word line writeback and refill against main memory through a req/ack handshake, stalling the pipeline.

Parameters:
- ADDR_BITS, 32, address width
- WORD_BITS, 32, data word width
- TAG_BITS, 22, tag width, equals cache tag output width
- LINE_WORDS, 4, words per line; word counter is log2(LINE_WORDS) bits
- WORD_BYTES, 4, bytes per word; byte offset is addr[1:0]

Ports:
- clk  in  1  system clock; cache array samples status on negedge and writes on posedge
- rst  in  1  asynchronous reset, active-low
- cpu_req  in  1  CPU memory access request
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; held stable while cpu_stall=1
- cpu_din  in  32  store data; held stable while cpu_stall=1
- cpu_dout  out  32  load data, equals cache_dout
- cpu_stall  out  1  freeze pipeline
- cache_addr  out  32  address to cache array
- cache_load  out  1  refill write strobe (sets valid, clears dirty, writes tag and data)
- cache_edit  out  1  store-hit strobe (sets dirty, writes data)
- cache_invalid  out  1  tied 0 in this revision
- cache_din  out  32  data to cache array
- cache_hit, cache_valid, cache_dirty  in  1 each  cache status for cache_addr
- cache_tag  in  22  stored tag of indexed line
- cache_dout  in  32  indexed word
- mem_cs  out  1  memory request
- mem_we  out  1  1 = memory write
- mem_addr  out  32  word-aligned memory address
- mem_dout  out  32  data to memory
- mem_din  in  32  data from memory
- mem_ack  in  1  memory word done, sampled on posedge clk

Behaviour:
- Address split: tag = addr[31:10], index = addr[9:4], word = addr[3:2].
- States: S_IDLE, S_BACK, S_FILL, S_RETRY. Registered state and 2-bit word counter cnt. All outputs decoded from state, cnt and inputs.
- Reset (rst=0, async): state=S_IDLE, cnt=0. All strobes, mem_cs, mem_we and cpu_stall are forced 0 while rst=0. Cache array contents are untouched. An in-flight memory transaction is abandoned: mem_cs drops immediately.
- S_IDLE:
  - cache_addr=cpu_addr, cache_din=cpu_din.
  - cpu_stall = cpu_req & ~cache_hit. A hit load completes in the same cycle with zero stall.
  - cache_edit = cpu_req & cpu_we & cache_hit.
  - On cpu_req & ~cache_hit at posedge: cnt<=0. If cache_valid & cache_dirty, go to S_BACK; otherwise go to S_FILL.
- S_BACK (victim writeback):
  - cpu_stall=1, mem_cs=1, mem_we=1.
  - cache_addr = {cpu_addr[31:4], cnt, 2'b00}.
  - mem_addr = {cache_tag, cpu_addr[9:4], cnt, 2'b00}; mem_dout=cache_dout.
  - On mem_ack: cnt++. When cnt==3 with ack, cnt<=0 and go to S_FILL.
- S_FILL:
  - cpu_stall=1, mem_cs=1, mem_we=0.
  - mem_addr = cache_addr = {cpu_addr[31:4], cnt, 2'b00}; cache_din=mem_din.
  - cache_load = mem_ack. cnt++ on ack. When cnt==3 with ack, go to S_RETRY.
- S_RETRY: cpu_stall=1, no strobes. Exists so the cache re-evaluates hit on the next negedge. Unconditionally go to S_IDLE, where the access replays and hits; a write miss completes there via cache_edit.
- Miss penalty: clean miss = 4 acked fill words + 1 retry cycle. Dirty miss adds 4 acked writeback words.
- mem_ack outside S_BACK/S_FILL is ignored. mem_ack held low stalls indefinitely with cnt frozen.
- cpu_req dropping mid-miss does not abort; the line still completes, then S_IDLE.
- cnt wraps 3->0 only on state exit.

Test Plan:
- Reset, cold load 0x00000104, memory acks after 2 cycles -> mem reads 0x100, 0x104, 0x108, 0x10C; 4 cache_load pulses; S_RETRY; hit; cpu_dout = mem word at 0x104; cpu_stall high for exactly 4×2+1+… cycles as computed by the bench model.
- After that fill, store 0xDEADBEEF to 0x00000108 -> single cycle, cache_edit=1, cpu_stall=0, no mem_cs.
- Then load 0x00000504 (index 0x10, tag differs) -> S_BACK writes 0x100..0x10C including 0xDEADBEEF at 0x108; S_FILL reads 0x500..0x50C; cpu_dout = mem[0x504].
- Store miss to 0x00000904 with clean victim -> no writeback; fill 0x900..0x90C; then cache_edit in S_IDLE; cache_dirty=1 afterwards.
- Assert rst=0 after second FILL ack -> mem_cs, cache_load, cpu_stall drop immediately; state S_IDLE, cnt 0 after release.
- Hold mem_ack=0 for 50 cycles in S_FILL -> cpu_stall stays 1, mem_addr constant, no cache_load.
